ioctl_cfg_capture: RTL and testbench
====================================

IOCTL_CFG_CAPTURE -- requirements
Module: ioctl_cfg_capture

Interface
REQ-001 Parameter NUM_CH, default 8, sets the number of independent configuration channels (1..16).
REQ-002 Parameter BYTES_PER_CH, default 8, sets the bytes stored per channel (1..64, power of two not required).
REQ-003 Parameter CH_INDEX, default 64'hFE08070605030201, is a packed NUM_CH*8 table giving the ioctl_index owned by each channel; channel 0 is in bits [7:0].
REQ-004 Parameter CLEAR_ON_START, default 1: 1 loads zeros into the shadow at load start; 0 loads the current live bytes, so partial downloads act as patches.
REQ-005 clk_sys  in  1  system clock; every register is on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ioctl_download  in  1  HPS download active.
REQ-008 ioctl_wr  in  1  byte write strobe, one cycle per byte.
REQ-009 ioctl_addr  in  25  byte offset within the current download.
REQ-010 ioctl_index  in  8  download target index.
REQ-011 ioctl_dout  in  8  write data byte.
REQ-012 cfg_data  out  NUM_CH*BYTES_PER_CH*8  live bytes; channel c, byte b is at bit offset (c*BYTES_PER_CH+b)*8.
REQ-013 cfg_valid  out  NUM_CH  channel has been committed at least once since reset.
REQ-014 cfg_update  out  NUM_CH  one-cycle pulse when that channel commits.
REQ-015 cfg_overflow  out  NUM_CH  sticky: the last load of that channel received an address >= BYTES_PER_CH.
REQ-016 busy  out  1  high in the LOAD and COMMIT states.

Function
REQ-017 The FSM states SHALL be IDLE, LOAD and COMMIT.
REQ-018 IDLE->LOAD SHALL occur on an edge where ioctl_download=1 and ioctl_index matches a CH_INDEX entry.
  - On that edge the channel number and the index SHALL be latched.
  - The shadow SHALL be initialised per CLEAR_ON_START.
  - That channel's cfg_overflow SHALL be cleared.
REQ-019 If ioctl_index matches more than one entry, the lowest channel number SHALL win.
REQ-020 If ioctl_index matches no entry, the FSM SHALL remain in IDLE and every write SHALL be ignored.
REQ-021 In LOAD, a write (ioctl_wr=1, ioctl_download=1, ioctl_index equal to the latched index, ioctl_addr<BYTES_PER_CH) SHALL store ioctl_dout into shadow byte ioctl_addr.
  - A later write to the same address SHALL overwrite the earlier one.
REQ-022 A write on the IDLE->LOAD edge SHALL be accepted; the write SHALL take precedence over the shadow initialisation for that byte.
REQ-023 A write in LOAD with ioctl_addr>=BYTES_PER_CH SHALL be discarded and SHALL set the latched channel's cfg_overflow.
REQ-024 A write in LOAD with an index different from the latched index SHALL be discarded without error.
REQ-025 LOAD->COMMIT SHALL occur on the first edge where ioctl_download=0.
REQ-026 COMMIT SHALL last exactly one cycle and then return to IDLE; on its exit edge the module SHALL:
  - copy the whole shadow into the latched channel's cfg_data slice atomically;
  - set that channel's cfg_valid;
  - drive that channel's cfg_update high for exactly the following cycle.
REQ-027 Live data SHALL therefore change 2 edges after ioctl_download is first sampled low.
REQ-028 No live byte SHALL change at any other time.
REQ-029 Other channels' cfg_data, cfg_valid and cfg_overflow SHALL be unaffected by a load or commit on a different channel.
REQ-030 A new download that starts while in COMMIT SHALL be recognised from IDLE on the next edge; it SHALL NOT be lost if ioctl_download is held high.
REQ-031 A download with zero writes SHALL still commit: zeros if CLEAR_ON_START=1, unchanged data if CLEAR_ON_START=0.

Reset
REQ-032 While reset=1, the module SHALL:
  - go to IDLE;
  - clear cfg_data, cfg_valid, cfg_update, cfg_overflow, busy and the shadow to 0.
REQ-033 Reset asserted in LOAD or COMMIT SHALL abort with no commit and no cfg_update pulse.
REQ-034 After reset releases with ioctl_download still high, the module SHALL NOT start a load until ioctl_download has been seen low once.

Verification
REQ-035 Index 254, addr 0..7 written with 8'h10..8'h17, download drops -> channel 7 bytes = 10..17 two edges after the drop; cfg_update[7] is a single pulse; cfg_valid=8'h80.
REQ-036 Index 3, 3 writes to addr 0..2 = AA,BB,CC followed by a write at addr 9 -> channel 2 = AA BB CC 00 00 00 00 00; cfg_overflow[2]=1; other channels are unchanged.
REQ-037 With CLEAR_ON_START=0, channel 0 preloaded 01..08, then a reload writing only addr 4 = FF -> channel 0 = 01 02 03 04 FF 06 07 08.
REQ-038 Index 9 (unmapped), 8 writes -> busy stays 0 and no output changes.
REQ-039 Reset asserted mid-LOAD after 4 writes to index 1 -> no cfg_update pulse and all outputs 0; a following download with ioctl_download held high across reset release is ignored until ioctl_download toggles.
REQ-040 Index 5 download ends; ioctl_download re-asserts with index 6 during COMMIT -> channel 3 commits, then a load of channel 4 starts with no write lost.

Source files
------------

// File: rtl/ioctl_cfg_capture.sv
// Captures per-channel config bytes from ioctl downloads into a shadow, committing atomically 2 edges after download drops.
// No backpressure: every ioctl write is accepted or silently dropped the cycle it arrives.
module ioctl_cfg_capture #(
    parameter int                  NUM_CH         = 8,
    parameter int                  BYTES_PER_CH   = 8,
    parameter logic [NUM_CH*8-1:0] CH_INDEX       = 64'hFE08070605030201,
    parameter bit                  CLEAR_ON_START = 1'b1
) (
    input  logic                             clk_sys,
    input  logic                             reset,
    input  logic                             ioctl_download,
    input  logic                             ioctl_wr,
    input  logic [24:0]                      ioctl_addr,
    input  logic [7:0]                       ioctl_index,
    input  logic [7:0]                       ioctl_dout,
    output logic [NUM_CH*BYTES_PER_CH*8-1:0] cfg_data,
    output logic [NUM_CH-1:0]                cfg_valid,
    output logic [NUM_CH-1:0]                cfg_update,
    output logic [NUM_CH-1:0]                cfg_overflow,
    output logic                             busy
);

    localparam int CH_W = BYTES_PER_CH * 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]      state;
    logic [3:0]      lat_ch;
    logic [7:0]      lat_idx;
    logic [CH_W-1:0] shadow;
    logic [CH_W-1:0] shadow_nxt;
    logic [CH_W-1:0] init_shadow;
    logic            armed;

    logic            match_hit;
    logic [3:0]      match_ch;
    logic            start_load;
    logic            wr_start;
    logic            wr_load;
    logic            wr_any;
    logic            addr_ok;

    // Descending scan so the lowest matching channel is the one left standing.
    always_comb begin
        match_hit = 1'b0;
        match_ch  = 4'd0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ioctl_index == CH_INDEX[c*8 +: 8]) begin
                match_hit = 1'b1;
                match_ch  = 4'(c);
            end
        end
    end

    assign start_load = (state == ST_IDLE) && armed && ioctl_download && match_hit;
    assign wr_start   = start_load && ioctl_wr;
    assign wr_load    = (state == ST_LOAD) && ioctl_wr && ioctl_download && (ioctl_index == lat_idx);
    assign wr_any     = wr_start || wr_load;
    assign addr_ok    = ioctl_addr < 25'(BYTES_PER_CH);

    always_comb begin
        init_shadow = '0;
        if (!CLEAR_ON_START) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (match_ch == 4'(c)) begin
                    init_shadow = cfg_data[c*CH_W +: CH_W];
                end
            end
        end
    end

    // The write lands on top of the initialised shadow, so a start-edge write wins.
    always_comb begin
        shadow_nxt = start_load ? init_shadow : shadow;
        if (wr_any && addr_ok) begin
            for (int b = 0; b < BYTES_PER_CH; b++) begin
                if (ioctl_addr == 25'(b)) begin
                    shadow_nxt[b*8 +: 8] = ioctl_dout;
                end
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= ST_IDLE;
            lat_ch       <= 4'd0;
            lat_idx      <= 8'd0;
            shadow       <= '0;
            armed        <= 1'b0;
            cfg_data     <= '0;
            cfg_valid    <= '0;
            cfg_update   <= '0;
            cfg_overflow <= '0;
        end else begin
            cfg_update <= '0;
            shadow     <= shadow_nxt;
            // A download already in progress at reset release must end before we listen.
            if (!ioctl_download) begin
                armed <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start_load) begin
                        state   <= ST_LOAD;
                        lat_ch  <= match_ch;
                        lat_idx <= ioctl_index;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (match_ch == 4'(c)) begin
                                cfg_overflow[c] <= wr_start && !addr_ok;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_load && !addr_ok) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (lat_ch == 4'(c)) begin
                                cfg_overflow[c] <= 1'b1;
                            end
                        end
                    end
                    if (!ioctl_download) begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (lat_ch == 4'(c)) begin
                            cfg_data[c*CH_W +: CH_W] <= shadow;
                            cfg_valid[c]             <= 1'b1;
                            cfg_update[c]            <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_COMMIT);

endmodule

// File: tb/tb_ioctl_cfg_capture.sv
// Directed bench: cycle table for the basic loads plus hand sequences for patching, back-to-back and reset abort.
module tb_ioctl_cfg_capture;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic         ioctl_download;
    logic         ioctl_wr;
    logic [24:0]  ioctl_addr;
    logic [7:0]   ioctl_index;
    logic [7:0]   ioctl_dout;

    logic [511:0] cfg_data,     nc_cfg_data;
    logic [7:0]   cfg_valid,    nc_cfg_valid;
    logic [7:0]   cfg_update,   nc_cfg_update;
    logic [7:0]   cfg_overflow, nc_cfg_overflow;
    logic         busy,         nc_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    ioctl_cfg_capture u_dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_index    (ioctl_index),
        .ioctl_dout     (ioctl_dout),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .cfg_update     (cfg_update),
        .cfg_overflow   (cfg_overflow),
        .busy           (busy)
    );

    ioctl_cfg_capture #(.CLEAR_ON_START(1'b0)) u_dut_nc (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_index    (ioctl_index),
        .ioctl_dout     (ioctl_dout),
        .cfg_data       (nc_cfg_data),
        .cfg_valid      (nc_cfg_valid),
        .cfg_update     (nc_cfg_update),
        .cfg_overflow   (nc_cfg_overflow),
        .busy           (nc_busy)
    );

    typedef struct {
        logic        dl;
        logic        wr;
        logic [24:0] addr;
        logic [7:0]  idx;
        logic [7:0]  dout;
        logic        exp_busy;
        logic [7:0]  exp_upd;
        logic [7:0]  exp_valid;
        int          ch;
        logic [63:0] exp_ch;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic dl, logic wr, logic [24:0] addr, logic [7:0] idx, logic [7:0] dout,
                                logic eb, logic [7:0] eu, logic [7:0] ev, int ch, logic [63:0] ed);
        vec_t v;
        v.dl = dl; v.wr = wr; v.addr = addr; v.idx = idx; v.dout = dout;
        v.exp_busy = eb; v.exp_upd = eu; v.exp_valid = ev; v.ch = ch; v.exp_ch = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic drive(input logic dl, input logic wr, input logic [24:0] addr, input logic [7:0] idx, input logic [7:0] dout);
        ioctl_download = dl;
        ioctl_wr       = wr;
        ioctl_addr     = addr;
        ioctl_index    = idx;
        ioctl_dout     = dout;
    endtask

    task automatic wr_byte(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] dout);
        drive(1'b1, 1'b1, addr, idx, dout);
        tick();
    endtask

    task automatic finish_dl();
        drive(1'b0, 1'b0, 25'd0, 8'd0, 8'd0);
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 25'd0, 8'd0, 8'd0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busy",     64'(busy),         64'd0);
        check("rst_valid",    64'(cfg_valid),    64'd0);
        check("rst_update",   64'(cfg_update),   64'd0);
        check("rst_overflow", 64'(cfg_overflow), 64'd0);
        check("rst_data",     64'(|cfg_data),    64'd0);

        // Channel 7 (index FE) full load.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 25'(i), 8'hFE, 8'(8'h10 + i), 1, 8'h00, 8'h00, 7, 64'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 7, 64'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h80, 8'h80, 7, 64'h1716151413121110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h80, 7, 64'h1716151413121110));
        // Channel 2 (index 3) partial load with an out-of-range write.
        tbl.push_back(mk(1, 1, 25'd0, 8'h03, 8'hAA, 1, 8'h00, 8'h80, 2, 64'd0));
        tbl.push_back(mk(1, 1, 25'd1, 8'h03, 8'hBB, 1, 8'h00, 8'h80, 2, 64'd0));
        tbl.push_back(mk(1, 1, 25'd2, 8'h03, 8'hCC, 1, 8'h00, 8'h80, 2, 64'd0));
        tbl.push_back(mk(1, 1, 25'd9, 8'h03, 8'h55, 1, 8'h00, 8'h80, 2, 64'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 8'h00, 8'h80, 2, 64'd0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h04, 8'h84, 2, 64'h0000000000CCBBAA));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h84, 2, 64'h0000000000CCBBAA));
        // Unmapped index 9: nothing may move.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1, 1, 25'(i), 8'h09, 8'(8'h90 + i), 0, 8'h00, 8'h84, 7, 64'h1716151413121110));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 8'h84, 2, 64'h0000000000CCBBAA));

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].dl, tbl[r].wr, tbl[r].addr, tbl[r].idx, tbl[r].dout);
            tick();
            check($sformatf("tbl%0d_busy", r),  64'(busy),       64'(tbl[r].exp_busy));
            check($sformatf("tbl%0d_upd", r),   64'(cfg_update), 64'(tbl[r].exp_upd));
            check($sformatf("tbl%0d_valid", r), 64'(cfg_valid),  64'(tbl[r].exp_valid));
            check($sformatf("tbl%0d_ch%0d", r, tbl[r].ch), cfg_data[tbl[r].ch*64 +: 64], tbl[r].exp_ch);
            check($sformatf("tbl%0d_nc_ch%0d", r, tbl[r].ch), nc_cfg_data[tbl[r].ch*64 +: 64], tbl[r].exp_ch);
        end
        check("ovf_ch2",    64'(cfg_overflow),    64'h04);
        check("nc_ovf_ch2", 64'(nc_cfg_overflow), 64'h04);
        check("idle_ch0",   cfg_data[0 +: 64],    64'd0);

        // Patch behaviour: preload channel 0, then rewrite only byte 4.
        for (int i = 0; i < 8; i++) wr_byte(8'h01, 25'(i), 8'(i + 1));
        finish_dl();
        check("pre_ch0",    cfg_data[0 +: 64],    64'h0807060504030201);
        check("nc_pre_ch0", nc_cfg_data[0 +: 64], 64'h0807060504030201);
        wr_byte(8'h01, 25'd4, 8'hFF);
        finish_dl();
        check("patch_ch0_clear", cfg_data[0 +: 64],    64'h000000FF00000000);
        check("patch_ch0_keep",  nc_cfg_data[0 +: 64], 64'h080706FF04030201);
        check("patch_nc_ch7",    nc_cfg_data[448 +: 64], 64'h1716151413121110);
        check("patch_valid",     64'(cfg_valid),     64'h85);
        check("patch_upd",       64'(nc_cfg_update), 64'h01);

        // Zero-write download.
        drive(1'b1, 1'b0, 25'd0, 8'h01, 8'd0);
        tick();
        finish_dl();
        check("zw_ch0_clear", cfg_data[0 +: 64],    64'd0);
        check("zw_ch0_keep",  nc_cfg_data[0 +: 64], 64'h080706FF04030201);

        // Back-to-back: index 5 commits while index 6 is already asserted.
        wr_byte(8'h05, 25'd0, 8'h11);
        wr_byte(8'h05, 25'd1, 8'h22);
        drive(1'b0, 1'b0, 25'd0, 8'd0, 8'd0);
        tick();
        check("b2b_commit_busy", 64'(busy), 64'd1);
        drive(1'b1, 1'b0, 25'd0, 8'h06, 8'd0);
        tick();
        check("b2b_upd3", 64'(cfg_update),  64'h08);
        check("b2b_ch3",  cfg_data[192 +: 64], 64'h0000000000002211);
        check("b2b_idle", 64'(busy), 64'd0);
        wr_byte(8'h06, 25'd0, 8'h33);
        check("b2b_load_busy", 64'(busy), 64'd1);
        wr_byte(8'h06, 25'd1, 8'h44);
        finish_dl();
        check("b2b_upd4", 64'(cfg_update),    64'h10);
        check("b2b_ch4",  cfg_data[256 +: 64], 64'h0000000000004433);

        // Reset mid-load, then download held high across release.
        for (int i = 0; i < 4; i++) wr_byte(8'h01, 25'(i), 8'(8'hA0 + i));
        reset = 1'b1;
        drive(1'b1, 1'b1, 25'd4, 8'h01, 8'hA4);
        tick();
        check("abort_busy",  64'(busy),         64'd0);
        check("abort_valid", 64'(cfg_valid),    64'd0);
        check("abort_upd",   64'(cfg_update),   64'd0);
        check("abort_ovf",   64'(cfg_overflow), 64'd0);
        check("abort_data",  64'(|cfg_data),    64'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_byte(8'h01, 25'(i), 8'h77);
            check($sformatf("held_busy%0d", i), 64'(busy),       64'd0);
            check($sformatf("held_upd%0d", i),  64'(cfg_update), 64'd0);
        end
        finish_dl();
        check("held_ch0",   cfg_data[0 +: 64], 64'd0);
        check("held_valid", 64'(cfg_valid),    64'd0);
        wr_byte(8'h01, 25'd0, 8'h5A);
        check("rearm_busy", 64'(busy), 64'd1);
        finish_dl();
        check("rearm_ch0",   cfg_data[0 +: 64], 64'h000000000000005A);
        check("rearm_valid", 64'(cfg_valid),    64'h01);
        check("rearm_upd",   64'(cfg_update),   64'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
